// File: rtl/ocs_4x4_cfg_sched.sv
// Reconfiguration sequencer for a 4x4 optical circuit switch built from six 2x2 elements.
// Optional build macro OCS_SCHED_PRIO_EN makes requester 0 urgent (bypasses slot hold and round-robin).
module ocs_4x4_cfg_sched #(
    parameter int   P_REQ_NUM   = 4,
    parameter int   P_GUARD_CYC = 16,
    parameter int   P_SLOT_MIN  = 64,
    parameter logic P_BAR       = 1'b0,
    parameter logic P_CROSS     = 1'b1
) (
    input  logic                   i_clk,
    input  logic                   i_rst_n,
    input  logic [P_REQ_NUM-1:0]   i_req_valid,
    input  logic [6*P_REQ_NUM-1:0] i_req_grant,
    output logic [P_REQ_NUM-1:0]   o_req_ready,
    output logic [5:0]             o_grant,
    output logic                   o_link_valid,
    output logic [2:0]             o_owner,
    output logic [15:0]            o_reconfig_cnt
);

    localparam int GW = $clog2(P_GUARD_CYC + 1);
    localparam int HW = $clog2(P_SLOT_MIN + 1);
    localparam logic [GW-1:0] GUARD_LAST = GW'(P_GUARD_CYC - 1);
    localparam logic [HW-1:0] HOLD_LAST  = HW'(P_SLOT_MIN - 1);

    localparam logic [1:0] ST_GUARD  = 2'd0;
    localparam logic [1:0] ST_ACTIVE = 2'd1;
    localparam logic [1:0] ST_ARB    = 2'd2;

    if (P_REQ_NUM < 2 || P_REQ_NUM > 8) begin : g_bad_req_num
        $error("P_REQ_NUM must be in 2..8");
    end
    if (P_BAR == P_CROSS) begin : g_bad_codes
        $error("P_BAR and P_CROSS must differ");
    end

    logic [1:0]           state_r;
    logic [GW-1:0]        guard_r;
    logic [HW-1:0]        hold_r;
    logic [2:0]           ptr_r;
    logic [5:0]           grant_r;
    logic                 link_r;
    logic [P_REQ_NUM-1:0] ready_r;
    logic [2:0]           owner_r;
    logic [15:0]          cnt_r;

    logic [7:0]           valid_pad_s;
    logic [47:0]          grant_pad_s;
    logic [3:0]           cand_s;
    logic                 win_found_s;
    logic [2:0]           win_idx_s;
    logic                 prio_win_s;
    logic [5:0]           req_vec_s;
    logic [P_REQ_NUM-1:0] ready_onehot_s;
    logic [2:0]           ptr_next_s;
    logic                 arb_trigger_s;

    // Round-robin winner search starting at the pointer, plus winner's vector and next pointer
    always_comb begin
        valid_pad_s    = 8'(i_req_valid);
        grant_pad_s    = 48'(i_req_grant);
        win_found_s    = 1'b0;
        win_idx_s      = 3'd0;
        prio_win_s     = 1'b0;
        cand_s         = 4'd0;
        req_vec_s      = grant_pad_s[5:0];
        ready_onehot_s = {P_REQ_NUM{1'b0}};
`ifdef OCS_SCHED_PRIO_EN
        if (valid_pad_s[0]) begin
            win_found_s = 1'b1;
            win_idx_s   = 3'd0;
            prio_win_s  = 1'b1;
        end else begin
        end
`endif
        for (int i = 0; i < P_REQ_NUM; i++) begin
            cand_s = {1'b0, ptr_r} + 4'(i);
            if (cand_s >= 4'(P_REQ_NUM)) begin
                cand_s = cand_s - 4'(P_REQ_NUM);
            end else begin
            end
            if (!win_found_s && valid_pad_s[cand_s[2:0]]) begin
                win_found_s = 1'b1;
                win_idx_s   = cand_s[2:0];
            end else begin
            end
        end
        for (int k = 0; k < 8; k++) begin
            if (win_idx_s == 3'(k)) begin
                req_vec_s = grant_pad_s[6*k +: 6];
            end else begin
            end
        end
        for (int k = 0; k < P_REQ_NUM; k++) begin
            ready_onehot_s[k] = win_found_s && (win_idx_s == 3'(k));
        end
        // An urgent override must not disturb the fairness order of the others
        if (prio_win_s) begin
            ptr_next_s = ptr_r;
        end else if (win_idx_s == 3'(P_REQ_NUM - 1)) begin
            ptr_next_s = 3'd0;
        end else begin
            ptr_next_s = win_idx_s + 3'd1;
        end
`ifdef OCS_SCHED_PRIO_EN
        arb_trigger_s = ((hold_r == HOLD_LAST) && (|i_req_valid)) || i_req_valid[0];
`else
        arb_trigger_s = (hold_r == HOLD_LAST) && (|i_req_valid);
`endif
    end

    // Sequencer: guard blanking, slot hold, single-cycle arbitration and grant update
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_r <= ST_GUARD;
            guard_r <= {GW{1'b0}};
            hold_r  <= {HW{1'b0}};
            ptr_r   <= 3'd0;
            grant_r <= {6{P_BAR}};
            link_r  <= 1'b0;
            ready_r <= {P_REQ_NUM{1'b0}};
            owner_r <= 3'd0;
            cnt_r   <= 16'd0;
        end else begin
            ready_r <= {P_REQ_NUM{1'b0}};
            case (state_r)
                ST_GUARD: begin
                    if (guard_r == GUARD_LAST) begin
                        state_r <= ST_ACTIVE;
                        link_r  <= 1'b1;
                        hold_r  <= {HW{1'b0}};
                    end else begin
                        guard_r <= guard_r + GW'(1'b1);
                    end
                end
                ST_ACTIVE: begin
                    if (hold_r != HOLD_LAST) begin
                        hold_r <= hold_r + HW'(1'b1);
                    end else begin
                    end
                    if (arb_trigger_s) begin
                        state_r <= ST_ARB;
                    end else begin
                    end
                end
                ST_ARB: begin
                    if (win_found_s) begin
                        ready_r <= ready_onehot_s;
                        owner_r <= win_idx_s;
                        ptr_r   <= ptr_next_s;
                        if (req_vec_s == grant_r) begin
                            state_r <= ST_ACTIVE;
                            hold_r  <= {HW{1'b0}};
                        end else begin
                            // Link drops on the same edge the fabric starts moving
                            grant_r <= req_vec_s;
                            link_r  <= 1'b0;
                            guard_r <= {GW{1'b0}};
                            state_r <= ST_GUARD;
                            if (cnt_r != 16'hFFFF) begin
                                cnt_r <= cnt_r + 16'd1;
                            end else begin
                            end
                        end
                    end else begin
                        state_r <= ST_ACTIVE;
                    end
                end
                default: begin
                    state_r <= ST_GUARD;
                    guard_r <= {GW{1'b0}};
                    link_r  <= 1'b0;
                end
            endcase
        end
    end

    assign o_req_ready    = ready_r;
    assign o_grant        = grant_r;
    assign o_link_valid   = link_r;
    assign o_owner        = owner_r;
    assign o_reconfig_cnt = cnt_r;

endmodule

// File: tb/tb_ocs_4x4_cfg_sched.sv
// Self-checking bench for ocs_4x4_cfg_sched: directed scenarios plus randomized traffic
// compared every cycle against a time-counting behavioural model.
module tb_ocs_4x4_cfg_sched;
    localparam int N = 4;
    localparam int G = 4;
    localparam int S = 8;

    logic           clk = 1'b0;
    logic           rst_n;
    logic [N-1:0]   req_valid;
    logic [6*N-1:0] req_grant;
    logic [N-1:0]   req_ready;
    logic [5:0]     grant;
    logic           link_valid;
    logic [2:0]     owner;
    logic [15:0]    reconfig_cnt;

    ocs_4x4_cfg_sched #(.P_REQ_NUM(N), .P_GUARD_CYC(G), .P_SLOT_MIN(S)) dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_req_valid(req_valid), .i_req_grant(req_grant),
        .o_req_ready(req_ready), .o_grant(grant), .o_link_valid(link_valid),
        .o_owner(owner), .o_reconfig_cnt(reconfig_cnt));

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_fail = 0;

    // Behavioural model: link blanks for G cycles after any change; arbitration runs in
    // the cycle after the link has been valid for at least S cycles with a request pending.
    logic [5:0]   m_grant;
    logic         m_link;
    logic [N-1:0] m_ready;
    int           m_owner, m_cnt, m_ptr, m_blank, m_age;
    logic         m_arb;
    logic [N-1:0] v_prev;
    logic [5:0]   prev_g;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at time %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_grant = 6'd0; m_link = 1'b0; m_ready = '0; m_owner = 0; m_cnt = 0;
        m_ptr = 0; m_blank = 0; m_age = 0; m_arb = 1'b0; v_prev = '0; prev_g = 6'd0;
    endtask

    task automatic model_step();
        int win;
        int c;
        logic [5:0] vec;
        v_prev = req_valid;
        m_ready = '0;
        if (!m_link) begin
            m_blank++;
            if (m_blank == G) begin
                m_link = 1'b1;
                m_age = 0;
            end
        end else if (m_arb) begin
            m_arb = 1'b0;
            win = -1;
            for (int i = 0; i < N; i++) begin
                c = (m_ptr + i) % N;
                if (win < 0 && req_valid[c]) win = c;
            end
            if (win >= 0) begin
                m_ready[win] = 1'b1;
                m_owner = win;
                m_ptr = (win + 1) % N;
                vec = req_grant[win*6 +: 6];
                if (vec != m_grant) begin
                    m_grant = vec;
                    m_link = 1'b0;
                    m_blank = 0;
                    if (m_cnt < 65535) m_cnt++;
                end else begin
                    m_age = 0;
                end
            end
        end else begin
            m_age++;
            if (m_age >= S && req_valid != '0) m_arb = 1'b1;
        end
    endtask

    task automatic compare_all();
        check("grant", 32'(grant), 32'(m_grant));
        check("link_valid", 32'(link_valid), 32'(m_link));
        check("req_ready", 32'(req_ready), 32'(m_ready));
        check("owner", 32'(owner), 32'(m_owner));
        check("reconfig_cnt", 32'(reconfig_cnt), 32'(m_cnt));
        check("ready_onehot", 32'($countones(req_ready) > 1), 32'd0);
        check("ready_to_valid", 32'(req_ready & ~v_prev), 32'd0);
        check("link_stable", 32'(link_valid && (grant !== prev_g)), 32'd0);
        prev_g = grant;
    endtask

    task automatic tick();
        @(posedge clk);
        if (rst_n) model_step();
        #1;
        compare_all();
    endtask

    task automatic drop_served();
        for (int k = 0; k < N; k++) begin
            if (req_ready[k]) req_valid[k] = 1'b0;
        end
    endtask

    task automatic wait_ready(input int budget, output logic got);
        got = 1'b0;
        for (int i = 0; i < budget && !got; i++) begin
            tick();
            if (req_ready != '0) got = 1'b1;
        end
        if (!got) check("ready_timeout", 32'd0, 32'd1);
    endtask

    task automatic check_guard_rise(input string name);
        for (int i = 1; i <= G; i++) begin
            tick();
            check(name, 32'(link_valid), 32'(i == G));
        end
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic got;
        int order[$];
        int rnd[N];
        rst_n = 1'b0;
        req_valid = '0;
        req_grant = '0;
        model_reset();
        #12;
        check("rst_grant", 32'(grant), 32'd0);
        check("rst_link", 32'(link_valid), 32'd0);
        check("rst_ready", 32'(req_ready), 32'd0);
        check("rst_owner", 32'(owner), 32'd0);
        check("rst_cnt", 32'(reconfig_cnt), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        check_guard_rise("first_guard");

        // Requester 2 asks at the first ACTIVE cycle; slot must elapse first
        req_valid[2] = 1'b1;
        req_grant[2*6 +: 6] = 6'b101101;
        for (int i = 1; i <= S; i++) begin
            tick();
            check("hold_no_ready", 32'(req_ready), 32'd0);
        end
        tick();
        check("r2_ready", 32'(req_ready), 32'b0100);
        check("r2_grant", 32'(grant), 32'b101101);
        check("r2_link", 32'(link_valid), 32'd0);
        check("r2_owner", 32'(owner), 32'd2);
        check("r2_cnt", 32'(reconfig_cnt), 32'd1);
        drop_served();
        for (int i = 1; i <= G; i++) begin
            tick();
            check("r2_guard", 32'(link_valid), 32'(i == G));
        end

        // Same-vector request: ready pulse, link never drops, count unchanged
        req_valid[1] = 1'b1;
        req_grant[1*6 +: 6] = 6'b101101;
        got = 1'b0;
        for (int i = 0; i < 20 && !got; i++) begin
            tick();
            check("eq_link_held", 32'(link_valid), 32'd1);
            if (req_ready != '0) got = 1'b1;
        end
        if (!got) check("eq_timeout", 32'd0, 32'd1);
        check("eq_ready", 32'(req_ready), 32'b0010);
        check("eq_cnt", 32'(reconfig_cnt), 32'd1);
        drop_served();
        tick();
        check("eq_link_after", 32'(link_valid), 32'd1);

        // Reset asserted in the second GUARD cycle after a change
        req_valid[3] = 1'b1;
        req_grant[3*6 +: 6] = 6'b010011;
        wait_ready(30, got);
        check("r3_ready", 32'(req_ready), 32'b1000);
        drop_served();
        tick();
        #2;
        rst_n = 1'b0;
        req_valid = '0;
        #1;
        model_reset();
        check("mid_rst_grant", 32'(grant), 32'd0);
        check("mid_rst_link", 32'(link_valid), 32'd0);
        check("mid_rst_cnt", 32'(reconfig_cnt), 32'd0);
        check("mid_rst_owner", 32'(owner), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        check_guard_rise("post_rst_guard");

        // Requesters 0,1,3 continuously valid: round-robin order 0,1,3,0
        for (int k = 0; k < N; k++) rnd[k] = 0;
        req_valid = 4'b1011;
        req_grant[0*6 +: 6] = 6'b000001;
        req_grant[1*6 +: 6] = 6'b010001;
        req_grant[3*6 +: 6] = 6'b110001;
        for (int i = 0; i < 300 && order.size() < 4; i++) begin
            tick();
            for (int k = 0; k < N; k++) begin
                if (req_ready[k]) begin
                    order.push_back(k);
                    rnd[k]++;
                    req_grant[k*6 +: 6] = {2'(k), 4'(rnd[k] + 1)};
                end
            end
        end
        check("rr_count", 32'(order.size()), 32'd4);
        if (order.size() == 4) begin
            check("rr_0", 32'(order[0]), 32'd0);
            check("rr_1", 32'(order[1]), 32'd1);
            check("rr_2", 32'(order[2]), 32'd3);
            check("rr_3", 32'(order[3]), 32'd0);
        end
        req_valid = '0;

        // Randomized traffic, including same-vector requests and early withdrawals
        for (int i = 0; i < 3000; i++) begin
            tick();
            drop_served();
            for (int k = 0; k < N; k++) begin
                if (!req_valid[k]) begin
                    if ($urandom_range(0, 9) == 0) begin
                        req_valid[k] = 1'b1;
                        if ($urandom_range(0, 3) == 0) req_grant[k*6 +: 6] = m_grant;
                        else req_grant[k*6 +: 6] = 6'($urandom);
                    end
                end else if ($urandom_range(0, 59) == 0) begin
                    req_valid[k] = 1'b0;
                end
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
